flasher_datapath: RTL and testbench
===================================

FLASHER_DATAPATH -- requirements
Module: flasher_datapath

Interface
REQ-001 The block SHALL have exactly one clock and use asynchronous, active-high reset: clk input 1, rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous active-high reset.
REQ-003 flick_raw  input  1  unsynchronised flick switch level from the board.
REQ-004 step_en  input  1  single-cycle advance strobe from the lamp-rate prescaler; state and counter update only when high.
REQ-005 main_state_n  input  3  next main state from next_state_generator.
REQ-006 counter_load  input  5  immediate counter load value from next_state_generator.
REQ-007 counter_load_en  input  1  immediate counter load enable.
REQ-008 count_state  input  2  count mode: COUNT_DIS=2'd0, COUNT_UP_EN=2'd1, COUNT_DOWN_EN=2'd2; 2'd3 reserved.
REQ-009 main_state  output  3  registered main state, fed back to next_state_generator.
REQ-010 counter  output  5  registered lamp counter, 0..16 in normal operation.
REQ-011 flick  output  1  synchronised flick level.
REQ-012 kickback_match  output  1  kickback condition to next_state_generator.
REQ-013 led  output  16  lamp bar.

Function
REQ-014 State encodings SHALL be the constants.h values: INIT=0, ONLED0_15=1, OFFLED15_5=2, ONLED5_10=3, OFFLED10_0=4, ONLED0_5=5, OFFLED5_0=6; 7 is illegal.
REQ-015 flick_raw SHALL pass through a 2-flop synchroniser, so flick equals flick_raw delayed by 2 clk edges, independent of step_en.
REQ-016 On a clk edge with step_en=1, main_state SHALL load main_state_n.
REQ-017 On a clk edge with step_en=1 and counter_load_en=1, counter SHALL load counter_load, overriding count_state.
REQ-018 On a clk edge with step_en=1 and counter_load_en=0, counter SHALL follow count_state: UP gives counter+1, saturating at 31; DOWN gives counter-1, saturating at 0; DIS or 2'd3 holds.
REQ-019 On a clk edge with step_en=0, main_state and counter SHALL hold regardless of every other input.
REQ-020 kickback_match SHALL be combinational from the registers and SHALL equal flick AND one of these conditions:
- main_state=OFFLED15_5 and counter=5.
- main_state=OFFLED10_0 and counter=0.
REQ-021 kickback_match SHALL be 0 in every other state/counter combination, including OFFLED5_0 at counter=0.
REQ-022 led SHALL be a combinational thermometer decode of counter: led[i]=1 iff i < counter. Counter values 16..31 give 16'hFFFF; 0 gives 16'h0000.
REQ-023 An illegal main_state (7) SHALL still register main_state_n on step_en. The block SHALL NOT self-correct it; correction is the responsibility of next_state_generator.
REQ-024 Outputs main_state, counter and flick SHALL come directly from flops with no combinational path from any input. kickback_match and led SHALL depend only on flops.

Reset
REQ-025 While rst=1, main_state=INIT, counter=0, both synchroniser flops=0, flick=0, kickback_match=0 and led=16'h0000, asynchronously and without needing a clk edge.
REQ-026 Reset asserted mid-sequence SHALL abort immediately to the REQ-025 values. After release, the first update SHALL occur on the first clk edge with step_en=1.
REQ-027 Reset release SHALL be treated as synchronous to clk by the integrating level; the block adds no release synchroniser.

Verification
REQ-028 Apply rst, then release; hold flick_raw=1 for 3 edges -> flick=0 after edge 1, flick=1 after edge 2, counter=0, led=16'h0000 throughout.
REQ-029 Drive count_state=UP with step_en pulsed every 4th cycle, 16 pulses -> counter increments only on pulse edges, ending at 16 with led=16'hFFFF; cycles without step_en show no change.
REQ-030 Set main_state=OFFLED15_5, counter=5, flick=1 -> kickback_match=1. Then apply counter_load=16, counter_load_en=1 and count_state=DOWN with step_en -> counter=16, not 4.
REQ-031 Set main_state=OFFLED10_0, counter=0: flick=0 -> kickback_match=0; flick=1 -> kickback_match=1. Set main_state=OFFLED5_0, counter=0, flick=1 -> kickback_match=0.
REQ-032 Saturation: counter=31 with UP and step_en -> stays 31. Counter=0 with DOWN -> stays 0. count_state=2'd3 -> holds.
REQ-033 Assert rst while main_state=ONLED5_10 and counter=9 -> immediate INIT/0/led 16'h0000 before the next clk edge, and all values are held until step_en after release.

Source files
------------

// File: rtl/flasher_datapath_if.sv
// Flasher datapath bus: controls from next_state_generator and the
// board, registered state and lamp outputs back to them.
interface flasher_datapath_if;
  logic        flick_raw;
  logic        step_en;
  logic [2:0]  main_state_n;
  logic [4:0]  counter_load;
  logic        counter_load_en;
  logic [1:0]  count_state;
  logic [2:0]  main_state;
  logic [4:0]  counter;
  logic        flick;
  logic        kickback_match;
  logic [15:0] led;

  modport master (
    output flick_raw, step_en, main_state_n,
    output counter_load, counter_load_en, count_state,
    input  main_state, counter, flick,
    input  kickback_match, led
  );

  modport slave (
    input  flick_raw, step_en, main_state_n,
    input  counter_load, counter_load_en, count_state,
    output main_state, counter, flick,
    output kickback_match, led
  );
endinterface

// File: rtl/flasher_datapath.sv
// Flasher datapath: state/counter registers, flick synchroniser,
// kickback detect and thermometer lamp decode.
module flasher_datapath (
  input logic               clk,
  input logic               rst,
  flasher_datapath_if.slave bus
);
  typedef enum logic [2:0] {
    INIT       = 3'd0,
    ONLED0_15  = 3'd1,
    OFFLED15_5 = 3'd2,
    ONLED5_10  = 3'd3,
    OFFLED10_0 = 3'd4,
    ONLED0_5   = 3'd5,
    OFFLED5_0  = 3'd6,
    ILLEGAL    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    COUNT_DIS     = 2'd0,
    COUNT_UP_EN   = 2'd1,
    COUNT_DOWN_EN = 2'd2,
    COUNT_RSVD    = 2'd3
  } count_e;

  state_e      st_q;
  logic [4:0]  cnt_q;
  logic [4:0]  cnt_d;
  logic        sync1_q;
  logic        sync2_q;
  logic [15:0] led_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.counter_load_en) begin
      cnt_d = bus.counter_load;
    end else begin
      case (count_e'(bus.count_state))
        COUNT_UP_EN:
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        COUNT_DOWN_EN:
          if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Illegal state 7 is registered as-is; recovery is upstream's job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= INIT;
      cnt_q <= 5'd0;
    end else if (bus.step_en) begin
      st_q  <= state_e'(bus.main_state_n);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.flick_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < 16; i++) begin
      led_d[i] = (int'(cnt_q) > i);
    end
  end

  assign bus.main_state     = st_q;
  assign bus.counter        = cnt_q;
  assign bus.flick          = sync2_q;
  assign bus.led            = led_d;
  assign bus.kickback_match = sync2_q &
    (((st_q == OFFLED15_5) && (cnt_q == 5'd5)) ||
     ((st_q == OFFLED10_0) && (cnt_q == 5'd0)));
endmodule

// File: tb/tb_flasher_datapath.sv
// Directed self-checking bench for flasher_datapath.
// Expected values are hand-derived constants.
module tb_flasher_datapath;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  flasher_datapath_if bus ();

  flasher_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] st,
                      input logic [4:0] cnt);
    bus.step_en         = 1'b1;
    bus.counter_load_en = 1'b1;
    bus.main_state_n    = st;
    bus.counter_load    = cnt;
    tick();
    bus.step_en         = 1'b0;
    bus.counter_load_en = 1'b0;
  endtask

  task automatic step(input logic [1:0] mode);
    bus.count_state = mode;
    bus.step_en     = 1'b1;
    tick();
    bus.step_en     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst                 = 1'b1;
    bus.flick_raw       = 1'b0;
    bus.step_en         = 1'b0;
    bus.main_state_n    = 3'd0;
    bus.counter_load    = 5'd0;
    bus.counter_load_en = 1'b0;
    bus.count_state     = 2'd0;
    #2;
    chk("rst_state", bus.main_state, 0);
    chk("rst_cnt", bus.counter, 0);
    chk("rst_flick", bus.flick, 0);
    chk("rst_kick", bus.kickback_match, 0);
    chk("rst_led", bus.led, 0);
    tick();
    rst = 1'b0;

    // synchroniser latency
    bus.flick_raw = 1'b1;
    tick();
    chk("sync_e1", bus.flick, 0);
    chk("sync_e1_led", bus.led, 0);
    tick();
    chk("sync_e2", bus.flick, 1);
    tick();
    chk("sync_e3", bus.flick, 1);
    chk("sync_cnt", bus.counter, 0);
    chk("sync_led", bus.led, 0);

    // count up on strobes only
    bus.count_state = 2'd1;
    for (int p = 0; p < 16; p++) begin
      bus.step_en = 1'b1;
      tick();
      bus.step_en = 1'b0;
      chk("up_step", bus.counter, p + 1);
      chk("up_led", bus.led, (32'h1 << (p + 1)) - 1);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("up_hold", bus.counter, p + 1);
      end
    end
    chk("up_end", bus.counter, 16);
    chk("up_end_led", bus.led, 16'hFFFF);

    // kickback at OFFLED15_5 / 5, load overrides down-count
    load(3'd2, 5'd5);
    chk("kb15_5", bus.kickback_match, 1);
    chk("kb15_5_led", bus.led, 16'h001F);
    bus.counter_load_en = 1'b1;
    bus.counter_load    = 5'd16;
    step(2'd2);
    bus.counter_load_en = 1'b0;
    chk("load_over", bus.counter, 16);
    chk("kb15_5_off", bus.kickback_match, 0);
    load(3'd2, 5'd4);
    chk("kb15_5_c4", bus.kickback_match, 0);

    // kickback at OFFLED10_0 / 0 gated by flick
    load(3'd4, 5'd0);
    bus.flick_raw = 1'b0;
    tick();
    tick();
    chk("kb10_0_nf", bus.kickback_match, 0);
    bus.flick_raw = 1'b1;
    tick();
    tick();
    chk("kb10_0_f", bus.kickback_match, 1);
    load(3'd6, 5'd0);
    chk("kb5_0", bus.kickback_match, 0);

    // saturation and hold modes
    load(3'd1, 5'd31);
    chk("led_31", bus.led, 16'hFFFF);
    step(2'd1);
    chk("sat_up", bus.counter, 31);
    load(3'd1, 5'd0);
    step(2'd2);
    chk("sat_dn", bus.counter, 0);
    load(3'd1, 5'd9);
    step(2'd3);
    chk("rsvd_hold", bus.counter, 9);
    step(2'd0);
    chk("dis_hold", bus.counter, 9);
    step(2'd2);
    chk("dn", bus.counter, 8);
    bus.counter_load_en = 1'b1;
    bus.counter_load    = 5'd20;
    bus.main_state_n    = 3'd5;
    tick();
    bus.counter_load_en = 1'b0;
    chk("noen_cnt", bus.counter, 8);
    chk("noen_st", bus.main_state, 1);

    // illegal state passes through
    bus.main_state_n = 3'd7;
    step(2'd0);
    chk("ill_st", bus.main_state, 7);
    bus.main_state_n = 3'd3;
    step(2'd0);
    chk("ill_exit", bus.main_state, 3);

    // async reset mid-sequence
    load(3'd3, 5'd9);
    chk("pre_rst_led", bus.led, 16'h01FF);
    rst = 1'b1;
    #1;
    chk("arst_st", bus.main_state, 0);
    chk("arst_cnt", bus.counter, 0);
    chk("arst_led", bus.led, 0);
    chk("arst_flick", bus.flick, 0);
    chk("arst_kick", bus.kickback_match, 0);
    bus.main_state_n = 3'd5;
    bus.step_en      = 1'b1;
    tick();
    chk("rst_hold_st", bus.main_state, 0);
    rst = 1'b0;
    bus.step_en = 1'b0;
    tick();
    tick();
    chk("post_st", bus.main_state, 0);
    chk("post_cnt", bus.counter, 0);
    step(2'd1);
    chk("post_step_st", bus.main_state, 5);
    chk("post_step_cnt", bus.counter, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
